// File: rtl/irq_claim_ctrl_if.sv
// rtl/irq_claim_ctrl_if.sv - arbiter and core handshake bundle for irq_claim_ctrl
interface irq_claim_ctrl_if #(
    parameter int NrIrqs    = 32,
    parameter int PrioWidth = 8
);
    localparam int IdxWidth = $clog2(NrIrqs);

    logic [NrIrqs-1:0]    pend_o;
    logic                 arb_valid_i;
    logic [IdxWidth-1:0]  arb_idx_i;
    logic [PrioWidth-1:0] arb_prio_i;
    logic                 irq_req_o;
    logic [IdxWidth-1:0]  irq_id_o;
    logic [PrioWidth-1:0] irq_prio_o;
    logic                 irq_ack_i;
    logic                 irq_done_i;

    modport slave (
        input  arb_valid_i, arb_idx_i, arb_prio_i, irq_ack_i, irq_done_i,
        output pend_o, irq_req_o, irq_id_o, irq_prio_o
    );

    modport master (
        output arb_valid_i, arb_idx_i, arb_prio_i, irq_ack_i, irq_done_i,
        input  pend_o, irq_req_o, irq_id_o, irq_prio_o
    );
endinterface

// File: rtl/irq_claim_ctrl.sv
// rtl/irq_claim_ctrl.sv - interrupt pending capture, core request/ack handshake and nesting stack
// Optional macro IRQ_THRESHOLD_EN adds threshold_i to the request condition.
module irq_claim_ctrl #(
    parameter  int NrIrqs    = 32,
    parameter  int PrioWidth = 8,
    parameter  int NestDepth = 4,
    localparam int IdxWidth  = $clog2(NrIrqs),
    localparam int CntWidth  = $clog2(NestDepth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NrIrqs-1:0]    irq_src_i,
    input  logic [NrIrqs-1:0]    edge_en_i,
`ifdef IRQ_THRESHOLD_EN
    input  logic [PrioWidth-1:0] threshold_i,
`endif
    irq_claim_ctrl_if.slave      bus,
    output logic [PrioWidth-1:0] cur_level_o,
    output logic [CntWidth-1:0]  nest_cnt_o,
    output logic                 nest_full_o
);
    typedef enum logic {IDLE, REQ} state_t;

    state_t               state_q;
    logic [NrIrqs-1:0]    src_q;
    logic [NrIrqs-1:0]    pend_q;
    logic [NrIrqs-1:0]    set_vec;
    logic [NrIrqs-1:0]    clr_vec;
    logic                 req_q;
    logic [IdxWidth-1:0]  id_q;
    logic [PrioWidth-1:0] prio_q;
    logic [PrioWidth-1:0] stack_q [NestDepth];
    logic [CntWidth-1:0]  cnt_q;
    logic [CntWidth-1:0]  cnt_pop;
    logic [CntWidth-1:0]  cnt_nxt;
    logic [PrioWidth-1:0] level_q;
    logic [PrioWidth-1:0] level_nxt;
    logic [PrioWidth-1:0] eff_level;
    logic                 full_q;
    logic                 ack_acc;
    logic                 pop;
    logic                 req_ok;

    assign ack_acc = (state_q == REQ) && bus.irq_ack_i;
    assign pop     = bus.irq_done_i && (cnt_q != '0);
    assign cnt_pop = cnt_q - CntWidth'(pop);
    assign cnt_nxt = cnt_pop + CntWidth'(ack_acc);

    assign set_vec = irq_src_i & (~edge_en_i | ~src_q);

    always_comb begin
        clr_vec = '0;
        if (ack_acc) clr_vec[id_q] = 1'b1;
    end

    // Pop happens before push, so a same-cycle done+ack replaces the top entry.
    always_comb begin
        level_nxt = '0;
        for (int i = 0; i < NestDepth; i++) begin
            if (cnt_pop == CntWidth'(i + 1)) level_nxt = stack_q[i];
        end
        if (ack_acc) level_nxt = prio_q;
    end

    always_comb begin
        eff_level = level_q;
`ifdef IRQ_THRESHOLD_EN
        if (threshold_i > level_q) eff_level = threshold_i;
`endif
    end

    assign req_ok = bus.arb_valid_i && (bus.arb_prio_i > eff_level) && !full_q;

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NestDepth; i++) begin
            if (ack_acc && (cnt_pop == CntWidth'(i))) stack_q[i] <= prio_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            src_q   <= '0;
            pend_q  <= '0;
            req_q   <= 1'b0;
            id_q    <= '0;
            prio_q  <= '0;
            cnt_q   <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
        end else begin
            src_q   <= irq_src_i;
            pend_q  <= (pend_q & ~clr_vec) | set_vec;
            cnt_q   <= cnt_nxt;
            level_q <= level_nxt;
            full_q  <= (cnt_nxt == CntWidth'(NestDepth));
            case (state_q)
                IDLE: begin
                    if (req_ok) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        id_q    <= bus.arb_idx_i;
                        prio_q  <= bus.arb_prio_i;
                    end
                end
                REQ: begin
                    // Target is frozen until the core acknowledges it.
                    if (bus.irq_ack_i) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pend_o     = pend_q;
    assign bus.irq_req_o  = req_q;
    assign bus.irq_id_o   = id_q;
    assign bus.irq_prio_o = prio_q;
    assign cur_level_o    = level_q;
    assign nest_cnt_o     = cnt_q;
    assign nest_full_o    = full_q;
endmodule

// File: tb/tb_irq_claim_ctrl.sv
// tb/tb_irq_claim_ctrl.sv - directed and randomized bench for irq_claim_ctrl against a queue-based model
module tb_irq_claim_ctrl;
    localparam int N  = 32;
    localparam int PW = 8;
    localparam int ND = 4;
    localparam int IW = 5;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  src;
    logic [N-1:0]  edge_en;
    logic [PW-1:0] level;
    logic [CW-1:0] cnt;
    logic          full;
`ifdef IRQ_THRESHOLD_EN
    logic [PW-1:0] thr;
`endif

    int n_checks = 0;
    int n_err    = 0;

    logic [PW-1:0] prio_tab [N];

    irq_claim_ctrl_if #(.NrIrqs(N), .PrioWidth(PW)) bus ();

    irq_claim_ctrl #(.NrIrqs(N), .PrioWidth(PW), .NestDepth(ND)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .irq_src_i   (src),
        .edge_en_i   (edge_en),
`ifdef IRQ_THRESHOLD_EN
        .threshold_i (thr),
`endif
        .bus         (bus.slave),
        .cur_level_o (level),
        .nest_cnt_o  (cnt),
        .nest_full_o (full)
    );

    always #5 clk = ~clk;

    // Combinational arbiter: highest priority wins, ties go to the lowest index.
    function automatic int arb_pick(input logic [N-1:0] p);
        int w;
        w = -1;
        for (int i = 0; i < N; i++) begin
            if (p[i] && (w < 0 || prio_tab[i] > prio_tab[w])) w = i;
        end
        return w;
    endfunction

    always_comb begin
        int w;
        w = arb_pick(bus.pend_o);
        bus.arb_valid_i = (w >= 0);
        bus.arb_idx_i   = IW'((w < 0) ? 0 : w);
        bus.arb_prio_i  = (w < 0) ? '0 : prio_tab[w];
    end

    bit [N-1:0] m_pend;
    bit [N-1:0] m_srcq;
    bit         m_req;
    int         m_id;
    int         m_prio;
    int         m_stk[$];

    function automatic int m_level();
        return (m_stk.size() == 0) ? 0 : m_stk[$];
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_srcq = '0;
        m_req  = 1'b0;
        m_id   = 0;
        m_prio = 0;
        m_stk.delete();
    endtask

    task automatic model_step(input logic [N-1:0] s, input logic a, input logic d);
        bit         acc;
        bit         is_full;
        int         eff;
        int         w;
        bit [N-1:0] np;
        acc     = m_req && a;
        is_full = (m_stk.size() == ND);
        eff     = m_level();
`ifdef IRQ_THRESHOLD_EN
        if (int'(thr) > eff) eff = int'(thr);
`endif
        w = arb_pick(m_pend);
        for (int i = 0; i < N; i++) begin
            np[i] = (s[i] && (!edge_en[i] || !m_srcq[i])) || (m_pend[i] && !(acc && i == m_id));
        end
        if (d && m_stk.size() > 0) void'(m_stk.pop_back());
        if (acc) m_stk.push_back(m_prio);
        if (!m_req) begin
            if (w >= 0 && int'(prio_tab[w]) > eff && !is_full) begin
                m_req  = 1'b1;
                m_id   = w;
                m_prio = int'(prio_tab[w]);
            end
        end else if (a) begin
            m_req = 1'b0;
        end
        m_pend = np;
        m_srcq = s;
    endtask

    task automatic compare_all();
        check("pend",  bus.pend_o,     m_pend);
        check("req",   bus.irq_req_o,  m_req);
        check("id",    bus.irq_id_o,   m_id);
        check("prio",  bus.irq_prio_o, m_prio);
        check("level", level,          m_level());
        check("cnt",   cnt,            m_stk.size());
        check("full",  full,           m_stk.size() == ND);
    endtask

    task automatic cyc(input logic [N-1:0] s, input logic a, input logic d);
        src            = s;
        bus.irq_ack_i  = a;
        bus.irq_done_i = d;
        @(posedge clk);
        model_step(s, a, d);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.irq_ack_i  = 1'b0;
        bus.irq_done_i = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        compare_all();
        rst = 1'b0;
    endtask

    task automatic serve(input int line);
        cyc(N'(1) << line, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0);
        check("serve_req", bus.irq_req_o, 1'b1);
        check("serve_id", bus.irq_id_o, line);
        cyc('0, 1'b1, 1'b0);
    endtask

    initial begin
        rst            = 1'b1;
        src            = '0;
        edge_en        = ~(N'(1) << 1);
        bus.irq_ack_i  = 1'b0;
        bus.irq_done_i = 1'b0;
`ifdef IRQ_THRESHOLD_EN
        thr = '0;
`endif
        for (int i = 0; i < N; i++) prio_tab[i] = '0;
        prio_tab[5] = 3; prio_tab[2] = 4; prio_tab[7] = 9; prio_tab[1] = 2;
        prio_tab[10] = 1; prio_tab[11] = 2; prio_tab[12] = 3; prio_tab[13] = 4;
        prio_tab[20] = 8; prio_tab[21] = 5; prio_tab[22] = 6;

        do_reset();
        check("rst_req", bus.irq_req_o, 1'b0);
        check("rst_pend", bus.pend_o, '0);

        // Single edge line through request and ack
        cyc(N'(1) << 5, 1'b0, 1'b0);
        check("edge_pend5", bus.pend_o[5], 1'b1);
        cyc('0, 1'b0, 1'b0);
        check("edge_req", bus.irq_req_o, 1'b1);
        check("edge_id", bus.irq_id_o, 5);
        check("edge_prio", bus.irq_prio_o, 3);
        cyc('0, 1'b1, 1'b0);
        check("ack_pend5", bus.pend_o[5], 1'b0);
        check("ack_level", level, 3);
        check("ack_cnt", cnt, 1);
        cyc('0, 1'b0, 1'b1);

        // Nesting: line 7 in service blocks line 2
        cyc((N'(1) << 7) | (N'(1) << 2), 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0);
        check("nest_id7", bus.irq_id_o, 7);
        cyc('0, 1'b1, 1'b0);
        check("nest_level9", level, 9);
        for (int k = 0; k < 3; k++) begin
            cyc('0, 1'b0, 1'b0);
            check("nest_blocked", bus.irq_req_o, 1'b0);
        end
        cyc('0, 1'b0, 1'b1);
        check("nest_level0", level, 0);
        cyc('0, 1'b0, 1'b0);
        check("nest_req2", bus.irq_req_o, 1'b1);
        check("nest_id2", bus.irq_id_o, 2);
        cyc('0, 1'b1, 1'b0);
        cyc('0, 1'b0, 1'b1);

        // Level line 1 held high through ack
        cyc(N'(1) << 1, 1'b0, 1'b0);
        cyc(N'(1) << 1, 1'b0, 1'b0);
        check("lvl_req", bus.irq_req_o, 1'b1);
        cyc(N'(1) << 1, 1'b1, 1'b0);
        check("lvl_repend", bus.pend_o[1], 1'b1);
        check("lvl_level2", level, 2);
        cyc(N'(1) << 1, 1'b0, 1'b0);
        cyc(N'(1) << 1, 1'b0, 1'b0);
        check("lvl_noreq", bus.irq_req_o, 1'b0);
        cyc(N'(1) << 1, 1'b0, 1'b1);
        cyc(N'(1) << 1, 1'b0, 1'b0);
        check("lvl_reissue", bus.irq_req_o, 1'b1);
        cyc('0, 1'b1, 1'b0);
        cyc('0, 1'b0, 1'b1);

        // Fill the nesting stack, then a prio-8 line waits for one done
        for (int l = 10; l <= 13; l++) serve(l);
        check("fill_full", full, 1'b1);
        cyc(N'(1) << 20, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc('0, 1'b0, 1'b0);
            check("full_noreq", bus.irq_req_o, 1'b0);
        end
        cyc('0, 1'b0, 1'b1);
        check("pop_full0", full, 1'b0);
        cyc('0, 1'b0, 1'b0);
        check("full_req8", bus.irq_prio_o, 8);
        check("full_req", bus.irq_req_o, 1'b1);
        cyc('0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) cyc('0, 1'b0, 1'b1);
        check("empty_done_cnt", cnt, 0);

        // Same-cycle done and ack at depth 2
        serve(10);
        serve(11);
        cyc(N'(1) << 13, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0);
        cyc('0, 1'b1, 1'b1);
        check("swap_cnt", cnt, 2);
        check("swap_level", level, 4);
        cyc('0, 1'b0, 1'b1);
        cyc('0, 1'b0, 1'b1);

        // Reset in the middle of a request
        cyc(N'(1) << 20, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0);
        check("pre_rst_req", bus.irq_req_o, 1'b1);
        do_reset();
        check("midrst_req", bus.irq_req_o, 1'b0);
        check("midrst_id", bus.irq_id_o, 0);
        check("midrst_pend", bus.pend_o, '0);

`ifdef IRQ_THRESHOLD_EN
        thr = 5;
        cyc(N'(1) << 21, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0);
        check("thr_block5", bus.irq_req_o, 1'b0);
        cyc(N'(1) << 22, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0);
        check("thr_req6", bus.irq_id_o, 22);
        check("thr_req", bus.irq_req_o, 1'b1);
        cyc('0, 1'b1, 1'b0);
        cyc('0, 1'b0, 1'b1);
        thr = 0;
        do_reset();
`endif

        // Randomized traffic
        for (int i = 0; i < N; i++) prio_tab[i] = PW'($urandom_range(0, 15));
        edge_en = N'($urandom);
        do_reset();
        for (int k = 0; k < 3000; k++) begin
`ifdef IRQ_THRESHOLD_EN
            if ($urandom_range(0, 99) == 0) thr = PW'($urandom_range(0, 10));
`endif
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cyc(N'($urandom & $urandom & $urandom),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
